// File: rtl/ram_arb_pkg.sv
// Shared types and host-selection helpers for the RAM port arbiter.
// rr_pick and fixed_pick both take the request vector zero-padded to MaxHostsLimit bits.
package ram_arb_pkg;

  localparam int MaxHostsLimit = 8;

  typedef logic [$clog2(MaxHostsLimit)-1:0] host_idx_t;

  // The search starts just after last and wraps at MaxHostsLimit. Padded request bits are zero,
  // so the effective wrap point is the real host count. last itself gets the lowest priority.
  function automatic host_idx_t rr_pick(input logic [MaxHostsLimit-1:0] req,
                                        input host_idx_t                last);
    host_idx_t idx;
    rr_pick = last;
    for (int i = MaxHostsLimit; i >= 1; i--) begin
      idx = last + host_idx_t'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic host_idx_t fixed_pick(input logic [MaxHostsLimit-1:0] req);
    fixed_pick = '0;
    for (int i = MaxHostsLimit - 1; i >= 0; i--) begin
      if (req[i]) fixed_pick = host_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Host-side and device-side bundle of the RAM port arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding hosts and device.
interface ram_arb_if #(
  parameter int NrHosts   = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);

  logic [NrHosts-1:0]                  host_req_i;
  logic [NrHosts-1:0]                  host_gnt_o;
  logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i;
  logic [NrHosts-1:0]                  host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i;
  logic [NrHosts-1:0]                  host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]   host_rdata_o;
  logic [NrHosts-1:0]                  host_err_o;

  logic                   dev_req_o;
  logic [AddrWidth-1:0]   dev_addr_o;
  logic                   dev_we_o;
  logic [DataWidth/8-1:0] dev_be_o;
  logic [DataWidth-1:0]   dev_wdata_o;
  logic                   dev_rvalid_i;
  logic [DataWidth-1:0]   dev_rdata_i;
  logic                   dev_err_i;
  logic                   spurious_o;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  dev_rvalid_i, dev_rdata_i, dev_err_i,
    output spurious_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output dev_rvalid_i, dev_rdata_i, dev_err_i,
    input  spurious_o
  );

endinterface

// File: rtl/ram_arb_tag_fifo.sv
// In-order FIFO of granted host indices, used to route each device response back to its host.
// A push and a pop in the same cycle are both accepted, even when the FIFO is full.
module ram_arb_tag_fifo
  import ram_arb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  logic      pop,
  input  host_idx_t wdata,
  output host_idx_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  host_idx_t       mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap at Depth, so depths that are not a power of two also work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one req/gnt/rvalid device port between NrHosts hosts. Each response is routed back through an in-order tag FIFO.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; without it the lowest requesting index wins.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input logic      clk_i,
  input logic      rst_i,
  ram_arb_if.slave bus
);

  logic [MaxHostsLimit-1:0] req_ext;
  host_idx_t                winner;
  host_idx_t                head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     can_issue;
  logic                     grant;

  always_comb begin
    req_ext = '0;
    req_ext[NrHosts-1:0] = bus.host_req_i;
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  host_idx_t last_q;

  assign winner = rr_pick(req_ext, last_q);

  // After reset, last_q points at the highest host, so host 0 wins the first grant.
  always_ff @(posedge clk_i) begin
    if (rst_i)      last_q <= host_idx_t'(NrHosts - 1);
    else if (grant) last_q <= winner;
  end
`else
  assign winner = fixed_pick(req_ext);
`endif

  // A pop in the same cycle frees a FIFO slot, so a grant can issue while the FIFO is full.
  assign pop       = bus.dev_rvalid_i && !fifo_empty && !rst_i;
  assign can_issue = !fifo_full || pop;
  assign grant     = (|bus.host_req_i) && can_issue && !rst_i;

  always_comb begin
    bus.host_gnt_o  = '0;
    bus.dev_req_o   = grant;
    bus.dev_addr_o  = '0;
    bus.dev_we_o    = 1'b0;
    bus.dev_be_o    = '0;
    bus.dev_wdata_o = '0;
    for (int i = 0; i < NrHosts; i++) begin
      if (grant && (winner == host_idx_t'(i))) begin
        bus.host_gnt_o[i] = 1'b1;
        bus.dev_addr_o    = bus.host_addr_i[i];
        bus.dev_we_o      = bus.host_we_i[i];
        bus.dev_be_o      = bus.host_be_i[i];
        bus.dev_wdata_o   = bus.host_wdata_i[i];
      end
    end
  end

  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    for (int i = 0; i < NrHosts; i++) begin
      bus.host_rdata_o[i] = bus.dev_rdata_i;
      if (pop && (head == host_idx_t'(i))) begin
        bus.host_rvalid_o[i] = 1'b1;
        bus.host_err_o[i]    = bus.dev_err_i;
      end
    end
  end

  // A response arriving when no tag is outstanding cannot be routed. It is dropped and the flag stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                 bus.spurious_o <= 1'b0;
    else if (bus.dev_rvalid_i && fifo_empty)   bus.spurious_o <= 1'b1;
  end

  ram_arb_tag_fifo #(
    .Depth (MaxOutstanding)
  ) u_tag_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (grant),
    .pop   (pop),
    .wdata (winner),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
